unstripe: RTL and testbench
===========================

# unstripe

- Byte-lane merger: receives two 32-bit lanes produced by the stripe stage and rebuilds the original single 32-bit stream in order (lane0 word, lane1 word, lane0 word, …).
- Sits at the receive end of the two-lane link, in the clk_2f domain.
- Each lane has a small FIFO so inter-lane skew of up to DEPTH-1 words is tolerated.
- Merged output is registered with a valid qualifier.

## Interface
- DEPTH, 4: per-lane FIFO depth in words; power of two, ≥2.
- clk_2f  input  1  2f clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- lane0  input  32  lane 0 data; each word held two clk_2f cycles.
- valid0  input  1  lane 0 qualifier; stays high across back-to-back words.
- lane1  input  32  lane 1 data; same format as lane0.
- valid1  input  1  lane 1 qualifier.
- dataOut  output  32  merged data word.
- validOut  output  1  dataOut carries a new word this cycle.
- overflow  output  1  sticky: a lane word was dropped on a full FIFO.

## Operation
- **Lane capture**, independent per lane k:
  - Phase bit ph_k is forced to 0 while valid_k=0 and toggles every edge while valid_k=1.
  - A word is captured (pushed into FIFO_k) on an edge where valid_k=1 and ph_k=0.
  - Result: the first cycle of a valid run, then every second cycle.
  - Words presented for a single cycle are still captured once.
- **FIFO_k**: DEPTH entries; write/read pointers of log2(DEPTH)+1 bits; full/empty from pointer compare; wrap-around by natural pointer overflow.
- **Read FSM** (2 bits):
  - IDLE: expects lane0; pops FIFO0 when non-empty, then goes to EXP1.
  - EXP0: pops FIFO0 when non-empty, then goes to EXP1; otherwise stays.
  - EXP1: pops FIFO1 when non-empty, then goes to EXP0; otherwise stays.
  - Return to IDLE from EXP0 or EXP1 when valid0=0, valid1=0 and both FIFOs are empty (link drained). This realigns to lane0 for the next burst.
  - Lane1 data never leaves before its preceding lane0 word.
- **Output**:
  - On a pop: dataOut ← popped word, validOut ← 1.
  - Otherwise validOut ← 0 and dataOut holds its last value.
- **Full FIFO**:
  - Push into a full FIFO with no same-edge pop: word dropped, pointers unchanged, overflow set.
  - Push and pop on the same edge while full: both happen, no drop.
- **Empty FIFO**: push and pop on the same edge when empty is not a bypass. The pop sees empty; the word is output one edge later.
- **overflow** clears only on reset.
- **Reset** (asynchronous, any time including mid-burst):
  - Pointers, ph_k, FSM (to IDLE), dataOut=0, validOut=0 and overflow=0 are cleared immediately.
  - FIFO contents are discarded.
  - After reset deassertion, the first edge is a normal edge.

## Timing
- Lane word captured at edge E → earliest dataOut/validOut at edge E+1 (1-cycle latency, no skew).
- Lane1 word arriving before its lane0 partner waits in FIFO1. It is output on the edge after the lane0 word is output.
- Sustained throughput: one output word per clk_2f cycle, given aligned stripe input (lane0 at cycles 0,2,4…; lane1 at cycles 1,3,5…).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- UNSTRIPE_OVERFLOW_EN:
  - Defined: overflow logic is built as described.
  - Undefined: the overflow port stays but is tied 0. A push into a full FIFO still drops the word, pointers are unchanged, and nothing is flagged.

## Test plan
- **Aligned burst**: reset low 2 cycles then high. Drive lane0=A0 at cycles 0–1, lane1=B0 at 1–2, lane0=A1 at 2–3, lane1=B1 at 3–4, with valids continuous. Expected: validOut=1 at edges 1–4 with dataOut = A0, B0, A1, B1; validOut=0 afterwards; overflow=0.
- **Lane skew**: lane1 lags lane0 by 3 cycles, words 0x11, 0x22 on lane0 and 0x33, 0x44 on lane1. Expected: output strictly 0x11, 0x33, 0x22, 0x44, with gaps where lane1 is late; FIFO0 never exceeds 2 entries.
- **Overflow**: DEPTH=4; feed 6 lane1 words with lane0 idle. Expected: no output; overflow=1 from the edge of the 5th push. Then feed 4 lane0 words. Expected output: L0w0, L1w0, L0w1, L1w1, …, L0w3, L1w3 (lane1 words 4–5 lost).
- **Full with simultaneous pop**: FIFO0 full, FSM in EXP0; push lane0 word on the pop edge. Expected: no drop, overflow stays 0, count stays 4.
- **Reset mid-burst**: assert reset with 2 words buffered. Expected immediately: validOut=0, dataOut=0, overflow=0. After release, a new burst starts with lane0 first; no stale words appear.
- **Drain realignment**: burst ends after an odd number of words (lane0 only), both valids low, FIFOs empty → FSM returns to IDLE. Next burst with words C0 (lane0) and D0 (lane1): output C0 then D0.

Source files
------------

// File: rtl/unstripe.sv
// unstripe: merges two striped 32-bit lanes back into one ordered stream.
// Define UNSTRIPE_OVERFLOW_EN to build the sticky overflow flag.
module unstripe #(
   parameter int DEPTH = 4
) (
   input  logic        clk_2f,
   input  logic        reset,
   input  logic [31:0] lane0,
   input  logic        valid0,
   input  logic [31:0] lane1,
   input  logic        valid1,
   output logic [31:0] dataOut,
   output logic        validOut,
   output logic        overflow
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXP0 = 2'd1,
      EXP1 = 2'd2
   } state_t;

   state_t state;

   logic [1:0][31:0] din;
   logic [1:0]       vin;
   logic [1:0][31:0] head;
   logic [1:0]       emp;
   logic [1:0]       pop;
`ifdef UNSTRIPE_OVERFLOW_EN
   logic [1:0]       drop;
`endif
   logic             drained;

   assign din = {lane1, lane0};
   assign vin = {valid1, valid0};

   genvar k;
   generate
      for (k = 0; k < 2; k++) begin : g_lane
         logic          ph;
         logic [AW:0]   wp;
         logic [AW:0]   rp;
         logic [31:0]   mem [DEPTH];
         logic          push;
         logic          full;
         logic          wr;

         assign emp[k] = (wp == rp);
         assign full   = (wp[AW] != rp[AW]) &&
                         (wp[AW-1:0] == rp[AW-1:0]);
         // ph low marks the first cycle of each two-cycle word
         assign push   = vin[k] & ~ph;
         assign wr     = push & (~full | pop[k]);
`ifdef UNSTRIPE_OVERFLOW_EN
         assign drop[k] = push & full & ~pop[k];
`endif
         assign head[k] = mem[rp[AW-1:0]];

         always_ff @(posedge clk_2f or negedge reset) begin
            if (!reset) begin
               ph <= 1'b0;
               wp <= '0;
               rp <= '0;
            end else begin
               ph <= vin[k] ? ~ph : 1'b0;
               if (wr)
                  wp <= wp + 1'b1;
               if (pop[k])
                  rp <= rp + 1'b1;
            end
         end

         always_ff @(posedge clk_2f) begin
            if (wr)
               mem[wp[AW-1:0]] <= din[k];
         end
      end
   endgenerate

   assign pop[0]  = (state != EXP1) && !emp[0];
   assign pop[1]  = (state == EXP1) && !emp[1];
   assign drained = !valid0 && !valid1 && emp[0] && emp[1];

   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         dataOut  <= '0;
         validOut <= 1'b0;
      end else begin
         validOut <= 1'b0;
         unique case (state)
            IDLE, EXP0: begin
               if (pop[0]) begin
                  state    <= EXP1;
                  dataOut  <= head[0];
                  validOut <= 1'b1;
               end else if (drained) begin
                  state <= IDLE;
               end
            end
            EXP1: begin
               if (pop[1]) begin
                  state    <= EXP0;
                  dataOut  <= head[1];
                  validOut <= 1'b1;
               end else if (drained) begin
                  // realign so the next burst starts on lane0
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UNSTRIPE_OVERFLOW_EN
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset)
         overflow <= 1'b0;
      else if (|drop)
         overflow <= 1'b1;
   end
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_unstripe.sv
// tb_unstripe: directed and random stimulus against a queue-based
// reference model of the two-lane merger.
module tb_unstripe;

   localparam int DEPTH = 4;
`ifdef UNSTRIPE_OVERFLOW_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic        clk_2f = 1'b0;
   logic        reset;
   logic [31:0] lane0, lane1;
   logic        valid0, valid1;
   logic [31:0] dataOut;
   logic        validOut;
   logic        overflow;

   always #5 clk_2f = ~clk_2f;

   unstripe #(.DEPTH(DEPTH)) dut (
      .clk_2f   (clk_2f),
      .reset    (reset),
      .lane0    (lane0),
      .valid0   (valid0),
      .lane1    (lane1),
      .valid1   (valid1),
      .dataOut  (dataOut),
      .validOut (validOut),
      .overflow (overflow)
   );

   int checks = 0;
   int failures = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];
   int          pos0, pos1;
   bit          want_l1;
   logic [31:0] m_data;
   bit          m_valid;
   bit          m_ovf;

   logic [31:0] got[$];
   logic [31:0] want[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      q0.delete();
      q1.delete();
      pos0 = 0;
      pos1 = 0;
      want_l1 = 1'b0;
      m_data = '0;
      m_valid = 1'b0;
      m_ovf = 1'b0;
   endtask

   // One clock edge of the reference: pop by lane order, then capture.
   task automatic model_edge(input bit v0, input logic [31:0] d0,
                             input bit v1, input logic [31:0] d1);
      bit c0, c1;
      c0 = v0 && (pos0 % 2 == 0);
      c1 = v1 && (pos1 % 2 == 0);
      m_valid = 1'b0;
      if (!want_l1 && q0.size() > 0) begin
         m_data = q0.pop_front();
         m_valid = 1'b1;
         want_l1 = 1'b1;
      end else if (want_l1 && q1.size() > 0) begin
         m_data = q1.pop_front();
         m_valid = 1'b1;
         want_l1 = 1'b0;
      end else if (!v0 && !v1 && q0.size() == 0 && q1.size() == 0) begin
         want_l1 = 1'b0;
      end
      if (c0) begin
         if (q0.size() < DEPTH) q0.push_back(d0);
         else m_ovf = 1'b1;
      end
      if (c1) begin
         if (q1.size() < DEPTH) q1.push_back(d1);
         else m_ovf = 1'b1;
      end
      pos0 = v0 ? pos0 + 1 : 0;
      pos1 = v1 ? pos1 + 1 : 0;
   endtask

   task automatic step(input bit v0, input logic [31:0] d0,
                       input bit v1, input logic [31:0] d1);
      valid0 = v0;
      lane0  = d0;
      valid1 = v1;
      lane1  = d1;
      @(posedge clk_2f);
      model_edge(v0, d0, v1, d1);
      #1;
      chk("validOut", {31'd0, validOut}, {31'd0, m_valid});
      chk("dataOut", dataOut, m_data);
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf & OVF_ON});
      if (validOut === 1'b1) got.push_back(dataOut);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
   endtask

   task automatic check_seq(input string name);
      chk({name, "_count"}, got.size(), want.size());
      for (int i = 0; i < got.size() && i < want.size(); i++)
         chk($sformatf("%s_w%0d", name, i), got[i], want[i]);
      got.delete();
   endtask

   task automatic do_reset(input int n);
      #2;
      reset  = 1'b0;
      valid0 = 1'b0;
      valid1 = 1'b0;
      lane0  = '0;
      lane1  = '0;
      model_clear();
      #1;
      chk("rst_validOut", {31'd0, validOut}, 32'd0);
      chk("rst_dataOut", dataOut, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      repeat (n) @(posedge clk_2f);
      @(negedge clk_2f);
      reset = 1'b1;
      #1;
      got.delete();
   endtask

   initial begin
      bit rv0, rv1;
      reset  = 1'b0;
      valid0 = 1'b0;
      valid1 = 1'b0;
      lane0  = '0;
      lane1  = '0;
      model_clear();
      do_reset(2);

      // aligned burst
      step(1, 32'hA000_0000, 0, 0);
      chk("al_e0_valid", {31'd0, validOut}, 32'd0);
      step(1, 32'hA000_0000, 1, 32'hB000_0000);
      chk("al_e1", dataOut, 32'hA000_0000);
      step(1, 32'hA000_0001, 1, 32'hB000_0000);
      chk("al_e2", dataOut, 32'hB000_0000);
      step(1, 32'hA000_0001, 1, 32'hB000_0001);
      chk("al_e3", dataOut, 32'hA000_0001);
      step(0, 0, 1, 32'hB000_0001);
      chk("al_e4", dataOut, 32'hB000_0001);
      step(0, 0, 0, 0);
      chk("al_e5_valid", {31'd0, validOut}, 32'd0);
      want = '{32'hA000_0000, 32'hB000_0000, 32'hA000_0001, 32'hB000_0001};
      check_seq("aligned");

      // lane1 lagging by 3 cycles
      do_reset(1);
      step(1, 32'h11, 0, 0);
      step(1, 32'h11, 0, 0);
      step(1, 32'h22, 0, 0);
      step(1, 32'h22, 1, 32'h33);
      step(0, 0, 1, 32'h33);
      chk("skew_e4", dataOut, 32'h33);
      step(0, 0, 1, 32'h44);
      step(0, 0, 1, 32'h44);
      idle(2);
      want = '{32'h11, 32'h33, 32'h22, 32'h44};
      check_seq("skew");

      // lane1 overruns its FIFO while lane0 is idle
      do_reset(1);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 1, 32'h1100_0000 + i);
         if (i == 3) chk("ovf_before", {31'd0, overflow}, 32'd0);
         if (i == 4) chk("ovf_5th", {31'd0, overflow}, {31'd0, OVF_ON});
         step(0, 0, 1, 32'h1100_0000 + i);
      end
      for (int j = 0; j < 4; j++) begin
         step(1, 32'h0100_0000 + j, 0, 0);
         step(1, 32'h0100_0000 + j, 0, 0);
      end
      idle(3);
      want = '{32'h0100_0000, 32'h1100_0000, 32'h0100_0001, 32'h1100_0001,
               32'h0100_0002, 32'h1100_0002, 32'h0100_0003, 32'h1100_0003};
      check_seq("overflow");
      chk("ovf_sticky", {31'd0, overflow}, {31'd0, OVF_ON});

      // full FIFO0 popped and pushed on the same edge
      do_reset(1);
      for (int j = 0; j < 5; j++) begin
         step(1, 32'hF000_0000 + j, 0, 0);
         if (j == 4) step(1, 32'hF000_0004, 1, 32'hC000_0000);
         else step(1, 32'hF000_0000 + j, 0, 0);
      end
      step(0, 0, 0, 0);
      step(1, 32'hF000_0005, 0, 0);
      chk("full_pop_ovf", {31'd0, overflow}, 32'd0);
      chk("full_pop_out", dataOut, 32'hF000_0001);
      step(1, 32'hF000_0005, 0, 0);
      for (int j = 1; j < 5; j++) begin
         step(0, 0, 1, 32'hC000_0000 + j);
         step(0, 0, 1, 32'hC000_0000 + j);
      end
      idle(3);
      want = '{32'hF000_0000, 32'hC000_0000, 32'hF000_0001, 32'hC000_0001,
               32'hF000_0002, 32'hC000_0002, 32'hF000_0003, 32'hC000_0003,
               32'hF000_0004, 32'hC000_0004, 32'hF000_0005};
      check_seq("fullpop");

      // reset with two words buffered
      do_reset(1);
      for (int j = 0; j < 3; j++) begin
         step(1, 32'h5000_0000 + j, 0, 0);
         step(1, 32'h5000_0000 + j, 0, 0);
      end
      chk("mid_before", dataOut, 32'h5000_0000);
      do_reset(2);
      step(1, 32'hC0C0_0000, 0, 0);
      step(1, 32'hC0C0_0000, 1, 32'hD0D0_0000);
      step(0, 0, 1, 32'hD0D0_0000);
      idle(3);
      want = '{32'hC0C0_0000, 32'hD0D0_0000};
      check_seq("after_reset");

      // odd burst, drain, then simultaneous lane words
      do_reset(1);
      step(1, 32'hE000_0000, 0, 0);
      step(1, 32'hE000_0000, 0, 0);
      idle(2);
      step(1, 32'hC1C1_0000, 1, 32'hD1D1_0000);
      step(1, 32'hC1C1_0000, 1, 32'hD1D1_0000);
      idle(3);
      want = '{32'hE000_0000, 32'hC1C1_0000, 32'hD1D1_0000};
      check_seq("realign");

      // random traffic with skew, gaps and occasional resets
      do_reset(1);
      rv0 = 1'b0;
      rv1 = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(7) == 0) rv0 = ~rv0;
         if ($urandom_range(7) == 0) rv1 = ~rv1;
         step(rv0, $urandom, rv1, $urandom);
         if ($urandom_range(999) == 0) begin
            do_reset(1);
            rv0 = 1'b0;
            rv1 = 1'b0;
         end
      end
      got.delete();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
